commit_trace_unit: RTL and testbench
====================================

# commit_trace_unit

Captures every ROB commit event in the mp4 out-of-order core and turns it into a clean, ordered, buffered retirement stream for the RVFI monitor and trace consumers. Sits directly downstream of the ROB head. Owns three jobs: per-commit order numbering, `pc_wdata` correction for JALR and mispredict redirects, and operand sanitisation (x0 / immediate-form register fields). Also owns halt detection, so the testbench top only wires `trace_*` to `rvfi.*`.

## Interface
- `DEPTH`, 8: trace FIFO entries; power of two, at least 2.
- `ORDER_W`, 64: width of the retirement order counter.
- `HALT_INST`, 32'h0007d463: instruction word that marks program end.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `commit_valid` in 1: the ROB retires its head entry this cycle.
- `commit_inst` in 32: instruction word of the retiring entry.
- `commit_pc` in 32: PC of the retiring entry.
- `commit_pc_next` in 32: next PC recorded by the ROB (sequential or predicted).
- `commit_rs1`, `commit_rs2` in 5 each: source register indices.
- `commit_rs1_data`, `commit_rs2_data` in 32 each: source operand values.
- `commit_rd` in 5: destination register index.
- `commit_rd_data` in 32: value written to the regfile.
- `commit_ld_regfile` in 1: the regfile is written by this commit.
- `commit_mispredict` in 1: the retiring branch mispredicted.
- `commit_target` in 32: resolved target when `commit_mispredict` is 1.
- `jalr_resolved` in 1: a reservation station finished a JALR this cycle.
- `jalr_target` in 32: target computed for that JALR.
- `commit_stall` out 1: FIFO is full; the ROB must not retire.
- `trace_valid` out 1: FIFO head holds a valid entry.
- `trace_ready` in 1: the consumer accepts the head entry.
- `trace_inst`, `trace_pc_rdata`, `trace_pc_wdata`, `trace_rs1_rdata`, `trace_rs2_rdata`, `trace_rd_wdata` out 32 each: fields of the head entry.
- `trace_rs1_addr`, `trace_rs2_addr`, `trace_rd_addr` out 5 each: register fields of the head entry.
- `trace_load_regfile` out 1: the head entry wrote the regfile.
- `trace_order` out `ORDER_W`: retirement order number of the head entry.
- `trace_halt` out 1: the head entry is the halt instruction.
- `halted` out 1: sticky; set once a halt entry has been accepted.
- `overflow` out 1: sticky; a commit arrived while the FIFO was full and was dropped.

## Operation
- **Enqueue.** A commit is accepted when `commit_valid` is 1, `halted` is 0, and the FIFO is not full. Full-with-simultaneous-dequeue counts as not full.
- **Order numbering.** Each accepted entry gets the current `order_cnt`, which then increments by 1. Dropped commits consume no order number. The counter wraps modulo 2^`ORDER_W`.
- **Operand sanitisation** is applied at enqueue, decoded from opcode `inst[6:0]`:
  - rs2 address and data are forced to 0 for opcodes 0010011, 0000011, 1100111, 0110111, 0010111 and 1101111.
  - rs1 address and data are forced to 0 for 0110111, 0010111 and 1101111.
  - For stores (0100011), rs2 is passed through unchanged.
  - `rd_wdata` is forced to 0 when `commit_rd` is 0 or `commit_ld_regfile` is 0.
- **pc_wdata selection**, in priority order:
  1. `commit_mispredict` selects `commit_target`.
  2. Otherwise, for JALR (opcode 1100111) with `jbuf_valid` set, select `jbuf`.
  3. Otherwise, select `commit_pc_next`.
- **JALR target buffer** (`jbuf`, `jbuf_valid`):
  - `jalr_resolved` loads `jbuf` and sets `jbuf_valid`.
  - An accepted JALR commit clears `jbuf_valid`.
  - When resolve and commit occur in the same cycle, the committing entry uses the incoming `jalr_target` and `jbuf_valid` ends at 0.
- **Halt.** An accepted entry whose `inst` equals `HALT_INST` sets `trace_halt` for that entry and sets `halted` on the same edge. All later commits are ignored: not enqueued, no order number consumed, `overflow` unchanged.
- **Dequeue.** The head entry is popped when `trace_valid` and `trace_ready` are both 1.
- **Backpressure.** `commit_stall = (count == DEPTH)`, combinational from the count. A commit received while full with no dequeue is dropped and sets `overflow`.
- **Pointers.** Read and write pointers are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits.

## Timing
- **Reset** (synchronous `rst` = 1) clears:
  - pointers, `count`, `order_cnt` and `jbuf`/`jbuf_valid`;
  - `halted` and `overflow`;
  - all `trace_*` outputs, which drive 0.
- A reset asserted mid-stream discards every buffered entry.
- **Enqueue-to-visible latency** is 1 cycle: an accepted commit at edge N appears as `trace_valid` after edge N when the FIFO was empty.
- **Outputs.** FIFO head fields are registered or driven from the RAM read pointer; there is no combinational path from `commit_*` to `trace_*`.
- **Throughput.** One enqueue and one dequeue per cycle, sustained.
- **Empty FIFO.** `trace_valid` is 0 and `trace_*` hold their last values.

## Test plan
- **Ordered stream.** Reset, then 3 back-to-back `addi` commits with `trace_ready` = 1. `trace_order` reads 0, 1, 2 on consecutive cycles, and `trace_rs2_addr` and `trace_rs2_rdata` are 0.
- **x0 write.** Commit with rd = 0 and `commit_rd_data` = 32'h1234. `trace_rd_wdata` = 0.
- **JALR and mispredict.** Assert `jalr_resolved` with target 32'h60 two cycles before the JALR commits, whose `commit_pc_next` = 32'h44. `trace_pc_wdata` = 32'h60. A following mispredicted branch with `commit_target` 32'h80 gives `trace_pc_wdata` = 32'h80.
- **Full and overflow.** Hold `trace_ready` = 0 and commit 8 entries: `commit_stall` = 1. Send a 9th commit: `overflow` = 1 and the order counter stays at 8. Then drain: orders 0–7 emerge in sequence.
- **Halt.** Commit `HALT_INST`, then 2 more commits. `trace_halt` = 1 on that entry, `halted` = 1, and no further entries appear.
- **Reset while loaded.** Load 4 entries, assert `rst` for 1 cycle. `trace_valid` = 0, and the next commit has `trace_order` = 0.

Source files
------------

// File: rtl/commit_trace_unit_if.sv
// Commit-side and trace-side signal bundle for commit_trace_unit.
// The ROB/testbench drives through master; the trace unit uses slave.
interface commit_trace_unit_if #(
  parameter int ORDER_W = 64
);
  logic               commit_valid;
  logic [31:0]        commit_inst;
  logic [31:0]        commit_pc;
  logic [31:0]        commit_pc_next;
  logic [4:0]         commit_rs1;
  logic [4:0]         commit_rs2;
  logic [31:0]        commit_rs1_data;
  logic [31:0]        commit_rs2_data;
  logic [4:0]         commit_rd;
  logic [31:0]        commit_rd_data;
  logic               commit_ld_regfile;
  logic               commit_mispredict;
  logic [31:0]        commit_target;
  logic               jalr_resolved;
  logic [31:0]        jalr_target;
  logic               commit_stall;

  logic               trace_valid;
  logic               trace_ready;
  logic [31:0]        trace_inst;
  logic [31:0]        trace_pc_rdata;
  logic [31:0]        trace_pc_wdata;
  logic [31:0]        trace_rs1_rdata;
  logic [31:0]        trace_rs2_rdata;
  logic [31:0]        trace_rd_wdata;
  logic [4:0]         trace_rs1_addr;
  logic [4:0]         trace_rs2_addr;
  logic [4:0]         trace_rd_addr;
  logic               trace_load_regfile;
  logic [ORDER_W-1:0] trace_order;
  logic               trace_halt;
  logic               halted;
  logic               overflow;

  modport master (
    output commit_valid, commit_inst, commit_pc, commit_pc_next,
           commit_rs1, commit_rs2, commit_rs1_data, commit_rs2_data,
           commit_rd, commit_rd_data, commit_ld_regfile,
           commit_mispredict, commit_target, jalr_resolved, jalr_target,
           trace_ready,
    input  commit_stall, trace_valid, trace_inst, trace_pc_rdata,
           trace_pc_wdata, trace_rs1_rdata, trace_rs2_rdata, trace_rd_wdata,
           trace_rs1_addr, trace_rs2_addr, trace_rd_addr, trace_load_regfile,
           trace_order, trace_halt, halted, overflow
  );

  modport slave (
    input  commit_valid, commit_inst, commit_pc, commit_pc_next,
           commit_rs1, commit_rs2, commit_rs1_data, commit_rs2_data,
           commit_rd, commit_rd_data, commit_ld_regfile,
           commit_mispredict, commit_target, jalr_resolved, jalr_target,
           trace_ready,
    output commit_stall, trace_valid, trace_inst, trace_pc_rdata,
           trace_pc_wdata, trace_rs1_rdata, trace_rs2_rdata, trace_rd_wdata,
           trace_rs1_addr, trace_rs2_addr, trace_rd_addr, trace_load_regfile,
           trace_order, trace_halt, halted, overflow
  );
endinterface

// File: rtl/commit_trace_unit.sv
// Turns ROB commits into an ordered, sanitised, buffered retirement trace
// with pc_wdata correction, halt detection and overflow reporting.
module commit_trace_unit #(
  parameter int          DEPTH     = 8,
  parameter int          ORDER_W   = 64,
  parameter logic [31:0] HALT_INST = 32'h0007d463
) (
  input logic               clk,
  input logic               rst,
  commit_trace_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic [31:0]        inst;
    logic [31:0]        pc_rdata;
    logic [31:0]        pc_wdata;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [31:0]        rs1_rdata;
    logic [31:0]        rs2_rdata;
    logic [4:0]         rd_addr;
    logic [31:0]        rd_wdata;
    logic               load_regfile;
    logic [ORDER_W-1:0] order;
    logic               halt;
  } entry_t;

  // Immediate-form and upper-immediate opcodes carry no rs2 operand.
  function automatic logic drops_rs2(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  function automatic logic drops_rs1(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  // A JALR resolving in the commit cycle itself wins over the stale buffer.
  function automatic logic [31:0] pick_pc_wdata(
    input logic        mispredict,
    input logic [31:0] target,
    input logic        is_jalr,
    input logic        resolved,
    input logic [31:0] resolved_target,
    input logic        buf_valid,
    input logic [31:0] buf_target,
    input logic [31:0] pc_next
  );
    if (mispredict)                return target;
    if (is_jalr && resolved)       return resolved_target;
    if (is_jalr && buf_valid)      return buf_target;
    return pc_next;
  endfunction

  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW-1:0]      head_idx;
  logic [CW-1:0]      count;
  logic [ORDER_W-1:0] order_cnt;
  logic [31:0]        jbuf;
  logic               jbuf_valid;
  logic               halted;
  logic               overflow;
  logic               show_zero;
  logic               full;
  logic               empty;
  logic               deq;
  logic               accept;
  logic               is_jalr;
  logic [6:0]         opcode;
  entry_t             enq_p0;
  entry_t             head_p1;
  entry_t             mem_p1 [DEPTH];

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign deq     = !empty && bus.trace_ready;
  assign accept  = bus.commit_valid && !halted && (!full || deq);
  assign opcode  = bus.commit_inst[6:0];
  assign is_jalr = (opcode == OP_JALR);

  // Stage p0: sanitise the retiring entry and stamp its order number.
  always_comb begin
    enq_p0              = '0;
    enq_p0.inst         = bus.commit_inst;
    enq_p0.pc_rdata     = bus.commit_pc;
    enq_p0.pc_wdata     = pick_pc_wdata(bus.commit_mispredict, bus.commit_target,
                                        is_jalr, bus.jalr_resolved, bus.jalr_target,
                                        jbuf_valid, jbuf, bus.commit_pc_next);
    enq_p0.rs1_addr     = drops_rs1(opcode) ? 5'd0  : bus.commit_rs1;
    enq_p0.rs1_rdata    = drops_rs1(opcode) ? 32'd0 : bus.commit_rs1_data;
    enq_p0.rs2_addr     = drops_rs2(opcode) ? 5'd0  : bus.commit_rs2;
    enq_p0.rs2_rdata    = drops_rs2(opcode) ? 32'd0 : bus.commit_rs2_data;
    enq_p0.rd_addr      = bus.commit_rd;
    enq_p0.rd_wdata     = (bus.commit_rd == 5'd0 || !bus.commit_ld_regfile)
                          ? 32'd0 : bus.commit_rd_data;
    enq_p0.load_regfile = bus.commit_ld_regfile;
    enq_p0.order        = order_cnt;
    enq_p0.halt         = (bus.commit_inst == HALT_INST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      order_cnt  <= '0;
      jbuf       <= '0;
      jbuf_valid <= 1'b0;
      halted     <= 1'b0;
      overflow   <= 1'b0;
      show_zero  <= 1'b1;
    end else begin
      if (accept) begin
        wptr      <= wptr + AW'(1);
        order_cnt <= order_cnt + ORDER_W'(1);
        show_zero <= 1'b0;
        if (enq_p0.halt) halted <= 1'b1;
      end
      if (deq) rptr <= rptr + AW'(1);
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, deq};
      if (bus.commit_valid && !halted && full && !deq) overflow <= 1'b1;
      if (bus.jalr_resolved) begin
        jbuf       <= bus.jalr_target;
        jbuf_valid <= 1'b1;
      end
      if (accept && is_jalr) jbuf_valid <= 1'b0;
    end
  end

  // Stage p1: storage; data is never reset, pointers alone define contents.
  always_ff @(posedge clk) begin
    if (accept) mem_p1[wptr] <= enq_p0;
  end

  // An empty FIFO keeps presenting the last popped entry; fresh reset shows zeros.
  assign head_idx = empty ? (rptr - AW'(1)) : rptr;
  assign head_p1  = show_zero ? '0 : mem_p1[head_idx];

  assign bus.commit_stall       = full;
  assign bus.trace_valid        = !empty;
  assign bus.trace_inst         = head_p1.inst;
  assign bus.trace_pc_rdata     = head_p1.pc_rdata;
  assign bus.trace_pc_wdata     = head_p1.pc_wdata;
  assign bus.trace_rs1_addr     = head_p1.rs1_addr;
  assign bus.trace_rs2_addr     = head_p1.rs2_addr;
  assign bus.trace_rs1_rdata    = head_p1.rs1_rdata;
  assign bus.trace_rs2_rdata    = head_p1.rs2_rdata;
  assign bus.trace_rd_addr      = head_p1.rd_addr;
  assign bus.trace_rd_wdata     = head_p1.rd_wdata;
  assign bus.trace_load_regfile = head_p1.load_regfile;
  assign bus.trace_order        = head_p1.order;
  assign bus.trace_halt         = head_p1.halt;
  assign bus.halted             = halted;
  assign bus.overflow           = overflow;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed and randomized checks of commit_trace_unit against a queue-based
// retirement model.
module tb_commit_trace_unit;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] HALT_INST = 32'h0007d463;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        load_regfile;
    logic [63:0] order;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst;
  commit_trace_unit_if #(.ORDER_W(64)) bus ();

  commit_trace_unit #(.DEPTH(DEPTH), .ORDER_W(64), .HALT_INST(HALT_INST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  exp_t        exp_q[$];
  logic [63:0] m_order;
  logic [31:0] m_jbuf;
  logic        m_jv;
  logic        m_halted;
  logic        m_ovf;

  function automatic exp_t model_entry();
    exp_t        e;
    logic [6:0]  op;
    logic        no_rs1, no_rs2;
    op     = bus.commit_inst[6:0];
    no_rs2 = op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
    no_rs1 = op inside {7'b0110111, 7'b0010111, 7'b1101111};
    e.inst      = bus.commit_inst;
    e.pc_rdata  = bus.commit_pc;
    if (bus.commit_mispredict)               e.pc_wdata = bus.commit_target;
    else if (op == 7'b1100111 && bus.jalr_resolved) e.pc_wdata = bus.jalr_target;
    else if (op == 7'b1100111 && m_jv)       e.pc_wdata = m_jbuf;
    else                                     e.pc_wdata = bus.commit_pc_next;
    e.rs1_addr  = no_rs1 ? 5'd0 : bus.commit_rs1;
    e.rs1_rdata = no_rs1 ? 32'd0 : bus.commit_rs1_data;
    e.rs2_addr  = no_rs2 ? 5'd0 : bus.commit_rs2;
    e.rs2_rdata = no_rs2 ? 32'd0 : bus.commit_rs2_data;
    e.rd_addr   = bus.commit_rd;
    e.rd_wdata  = (bus.commit_rd != 0 && bus.commit_ld_regfile) ? bus.commit_rd_data : 32'd0;
    e.load_regfile = bus.commit_ld_regfile;
    e.order     = m_order;
    e.halt      = (bus.commit_inst == HALT_INST);
    return e;
  endfunction

  function automatic exp_t dut_head();
    exp_t h;
    h = {bus.trace_inst, bus.trace_pc_rdata, bus.trace_pc_wdata,
         bus.trace_rs1_addr, bus.trace_rs2_addr, bus.trace_rs1_rdata,
         bus.trace_rs2_rdata, bus.trace_rd_addr, bus.trace_rd_wdata,
         bus.trace_load_regfile, bus.trace_order, bus.trace_halt};
    return h;
  endfunction

  // Advance the reference model by one edge using the inputs currently driven.
  task automatic tick();
    logic deq, acc;
    exp_t e;
    e   = '0;
    deq = (exp_q.size() != 0) && bus.trace_ready;
    if (rst) begin
      exp_q.delete();
      m_order  = '0;
      m_jbuf   = '0;
      m_jv     = 1'b0;
      m_halted = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      acc = bus.commit_valid && !m_halted && (exp_q.size() < DEPTH || deq);
      if (acc) e = model_entry();
      if (bus.commit_valid && !m_halted && !acc) m_ovf = 1'b1;
      if (deq) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(e);
        m_order = m_order + 64'd1;
        if (e.halt) m_halted = 1'b1;
      end
      if (bus.jalr_resolved) begin
        m_jbuf = bus.jalr_target;
        m_jv   = 1'b1;
      end
      if (acc && bus.commit_inst[6:0] == 7'b1100111) m_jv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.commit_valid      = 1'b0;
    bus.commit_mispredict = 1'b0;
    bus.jalr_resolved     = 1'b0;
  endtask

  task automatic drive_commit(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] pc_next, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] rs1d,
                              input logic [31:0] rs2d, input logic [4:0] rd,
                              input logic [31:0] rdd, input logic ld,
                              input logic mis, input logic [31:0] tgt);
    bus.commit_valid      = 1'b1;
    bus.commit_inst       = inst;
    bus.commit_pc         = pc;
    bus.commit_pc_next    = pc_next;
    bus.commit_rs1        = rs1;
    bus.commit_rs2        = rs2;
    bus.commit_rs1_data   = rs1d;
    bus.commit_rs2_data   = rs2d;
    bus.commit_rd         = rd;
    bus.commit_rd_data    = rdd;
    bus.commit_ld_regfile = ld;
    bus.commit_mispredict = mis;
    bus.commit_target     = tgt;
  endtask

  task automatic drive_addi(input logic [4:0] rd, input logic [31:0] rdd);
    drive_commit(32'h00708093, 32'h100, 32'h104, 5'd1, 5'd7, 32'h11, 32'hdead,
                 rd, rdd, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.trace_ready = 1'b0;
    do_reset();
    vectors++;
    if (bus.trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.trace_valid);
    end
    vectors++;
    if ({bus.commit_stall, bus.halted, bus.overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {bus.commit_stall, bus.halted, bus.overflow});
    end
    vectors++;
    if (dut_head() !== exp_t'('0)) begin
      miscompares++; $display("FAIL reset_trace_fields: got %h expected 0", dut_head());
    end
  endtask

  task automatic test_ordered_stream();
    do_reset();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_addi(5'd1, 32'd10 + i);
      tick();
      vectors++;
      if (bus.trace_valid !== 1'b1 || bus.trace_order !== 64'(i)) begin
        miscompares++;
        $display("FAIL stream_order[%0d]: got valid=%b order=%0d expected valid=1 order=%0d",
                 i, bus.trace_valid, bus.trace_order, i);
      end
      vectors++;
      if (bus.trace_rs2_addr !== 5'd0 || bus.trace_rs2_rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL stream_rs2[%0d]: got addr=%0d data=%h expected 0", i,
                 bus.trace_rs2_addr, bus.trace_rs2_rdata);
      end
    end
    idle();
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL stream_drained: got valid=%b expected 0", bus.trace_valid);
    end
  endtask

  task automatic test_x0_write();
    bus.trace_ready = 1'b1;
    drive_addi(5'd0, 32'h1234);
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b1 || bus.trace_rd_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_rd_wdata: got valid=%b wdata=%h expected valid=1 wdata=0",
               bus.trace_valid, bus.trace_rd_wdata);
    end
    idle();
    tick();
  endtask

  task automatic test_jalr_mispredict();
    bus.trace_ready   = 1'b1;
    idle();
    bus.jalr_resolved = 1'b1;
    bus.jalr_target   = 32'h60;
    tick();
    idle();
    tick();
    drive_commit(32'h000080e7, 32'h40, 32'h44, 5'd1, 5'd3, 32'h5c, 32'h77,
                 5'd1, 32'h44, 1'b1, 1'b0, 32'h0);
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b1 || bus.trace_pc_wdata !== 32'h60) begin
      miscompares++;
      $display("FAIL jalr_pc_wdata: got valid=%b pc_wdata=%h expected valid=1 pc_wdata=60",
               bus.trace_valid, bus.trace_pc_wdata);
    end
    drive_commit(32'h00208463, 32'h60, 32'h64, 5'd1, 5'd2, 32'h1, 32'h1,
                 5'd0, 32'h0, 1'b0, 1'b1, 32'h80);
    tick();
    vectors++;
    if (bus.trace_pc_wdata !== 32'h80) begin
      miscompares++;
      $display("FAIL mispredict_pc_wdata: got %h expected 80", bus.trace_pc_wdata);
    end
    vectors++;
    if (bus.trace_rs2_addr !== 5'd2) begin
      miscompares++;
      $display("FAIL branch_rs2_kept: got %0d expected 2", bus.trace_rs2_addr);
    end
    idle();
    tick();
  endtask

  task automatic test_full_overflow();
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_addi(5'd2, 32'd100 + i);
      tick();
      vectors++;
      if (bus.commit_stall !== (i == DEPTH - 1)) begin
        miscompares++;
        $display("FAIL fill_stall[%0d]: got %b expected %b", i, bus.commit_stall, (i == DEPTH - 1));
      end
    end
    drive_addi(5'd2, 32'd999);
    tick();
    vectors++;
    if (bus.overflow !== 1'b1 || bus.commit_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got overflow=%b stall=%b expected 1 1",
               bus.overflow, bus.commit_stall);
    end
    idle();
    bus.trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (bus.trace_valid !== 1'b1 || bus.trace_order !== 64'(i)) begin
        miscompares++;
        $display("FAIL drain_order[%0d]: got valid=%b order=%0d expected valid=1 order=%0d",
                 i, bus.trace_valid, bus.trace_order, i);
      end
      tick();
    end
    vectors++;
    if (bus.trace_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_empty: got valid=%b expected 0", bus.trace_valid);
    end
    drive_addi(5'd3, 32'h5);
    tick();
    vectors++;
    if (bus.trace_order !== 64'd8 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL post_overflow_order: got order=%0d overflow=%b expected 8 1",
               bus.trace_order, bus.overflow);
    end
    idle();
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    bus.trace_ready = 1'b0;
    drive_commit(HALT_INST, 32'h200, 32'h204, 5'd15, 5'd0, 32'h0, 32'h0,
                 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b1 || bus.trace_halt !== 1'b1 || bus.halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_flags: got valid=%b trace_halt=%b halted=%b expected 1 1 1",
               bus.trace_valid, bus.trace_halt, bus.halted);
    end
    for (int i = 0; i < 2; i++) begin
      drive_addi(5'd4, 32'd7);
      tick();
    end
    idle();
    bus.trace_ready = 1'b1;
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_no_more: got valid=%b overflow=%b halted=%b expected 0 0 1",
               bus.trace_valid, bus.overflow, bus.halted);
    end
  endtask

  task automatic test_reset_loaded();
    do_reset();
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_addi(5'd5, 32'd20 + i);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.trace_valid !== 1'b0 || bus.trace_inst !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_loaded_empty: got valid=%b inst=%h expected 0 0",
               bus.trace_valid, bus.trace_inst);
    end
    bus.trace_ready = 1'b1;
    drive_addi(5'd6, 32'd33);
    tick();
    vectors++;
    if (bus.trace_valid !== 1'b1 || bus.trace_order !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_loaded_order: got valid=%b order=%0d expected 1 0",
               bus.trace_valid, bus.trace_order);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b0100011, 7'b1100011, 7'b0110011};
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      vectors++;
      if (bus.trace_valid !== (exp_q.size() != 0) || bus.commit_stall !== (exp_q.size() == DEPTH)) begin
        miscompares++;
        $display("FAIL rand_status@%0d: got valid=%b stall=%b expected valid=%b stall=%b", cyc,
                 bus.trace_valid, bus.commit_stall, exp_q.size() != 0, exp_q.size() == DEPTH);
      end
      vectors++;
      if (bus.halted !== m_halted || bus.overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL rand_sticky@%0d: got halted=%b overflow=%b expected %b %b", cyc,
                 bus.halted, bus.overflow, m_halted, m_ovf);
      end
      if (exp_q.size() != 0) begin
        vectors++;
        if (dut_head() !== exp_q[0]) begin
          miscompares++;
          $display("FAIL rand_head@%0d: got %h expected %h", cyc, dut_head(), exp_q[0]);
        end
      end
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 8)];
      if (r == HALT_INST) r = r ^ 32'h80;
      drive_commit(r, $urandom(), $urandom(), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom(), $urandom(),
                   5'($urandom_range(0, 7)), $urandom(), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), $urandom());
      bus.commit_valid  = ($urandom_range(0, 3) != 0);
      bus.jalr_resolved = ($urandom_range(0, 3) == 0);
      bus.jalr_target   = $urandom();
      bus.trace_ready   = (cyc < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    exp_q.delete();
    m_order  = '0;
    m_jbuf   = '0;
    m_jv     = 1'b0;
    m_halted = 1'b0;
    m_ovf    = 1'b0;
    bus.trace_ready = 1'b0;
    drive_addi(5'd0, 32'd0);
    idle();
    bus.jalr_target = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_ordered_stream();
    test_x0_write();
    test_jalr_mispredict();
    test_full_overflow();
    test_halt();
    test_reset_loaded();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
